// File: rtl/uart_fifo.sv
// First-word-fall-through byte FIFO used on both sides of the UART loop-back path.
// Optional occupancy port `count` is built when UART_FIFO_COUNT_EN is defined.
module uart_fifo #(
    parameter int B = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         rd,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full
`ifdef UART_FIFO_COUNT_EN
    ,
    output logic [W:0]   count
`endif
);

    localparam int DEPTH = 1 << W;

    logic [B-1:0] mem_q [DEPTH];
    logic [W-1:0] w_ptr_q, w_ptr_d;
    logic [W-1:0] r_ptr_q, r_ptr_d;
    logic         empty_q, empty_d;
    logic         full_q, full_d;
    logic         wr_ok, rd_ok;

    // A write into a full FIFO is still taken when a pop frees the head slot in the same cycle.
    assign rd_ok = rd & ~empty_q;
    assign wr_ok = wr & (~full_q | rd_ok);

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        empty_d = empty_q;
        full_d  = full_q;
        case ({wr_ok, rd_ok})
            2'b10: begin
                w_ptr_d = w_ptr_q + W'(1);
                empty_d = 1'b0;
                full_d  = ((w_ptr_q + W'(1)) == r_ptr_q);
            end
            2'b01: begin
                r_ptr_d = r_ptr_q + W'(1);
                full_d  = 1'b0;
                empty_d = ((r_ptr_q + W'(1)) == w_ptr_q);
            end
            2'b11: begin
                w_ptr_d = w_ptr_q + W'(1);
                r_ptr_d = r_ptr_q + W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            if (wr_ok) begin
                mem_q[w_ptr_q] <= w_data;
            end
        end
    end

    assign r_data = mem_q[r_ptr_q];
    assign empty  = empty_q;
    assign full   = full_q;

`ifdef UART_FIFO_COUNT_EN
    logic [W:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (W+1)'(1);
            2'b01:   count_d = count_q - (W+1)'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo (B=8, W=2) against a queue-based occupancy model.
// Checks `count` too when UART_FIFO_COUNT_EN is defined.
module tb_uart_fifo;

    localparam int B = 8;
    localparam int W = 2;
    localparam int DEPTH = 1 << W;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         rd = 1'b0;
    logic         wr = 1'b0;
    logic [B-1:0] w_data = '0;
    logic [B-1:0] r_data;
    logic         empty;
    logic         full;
`ifdef UART_FIFO_COUNT_EN
    logic [W:0]   count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [B-1:0] model_q[$];

    uart_fifo #(.B(B), .W(W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .rd     (rd),
        .wr     (wr),
        .w_data (w_data),
        .r_data (r_data),
        .empty  (empty),
        .full   (full)
`ifdef UART_FIFO_COUNT_EN
        ,
        .count  (count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
        check({tag, ".full"},  32'(full),  32'(model_q.size() == DEPTH));
        if (model_q.size() != 0) begin
            check({tag, ".r_data"}, 32'(r_data), 32'(model_q[0]));
        end
`ifdef UART_FIFO_COUNT_EN
        check({tag, ".count"}, 32'(count), 32'(model_q.size()));
`endif
    endtask

    // Called at a negedge: drive, take the edge, update the model, check at the next negedge.
    task automatic step(input logic w, input logic r, input logic [B-1:0] d, input string tag);
        bit do_pop, do_push;
        wr = w;
        rd = r;
        w_data = d;
        @(posedge clk);
        do_pop  = r && (model_q.size() > 0);
        do_push = w && ((model_q.size() < DEPTH) || do_pop);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(d);
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [B-1:0] first;
        do_reset();
        check_state("reset");
        check("reset.r_data0", 32'(r_data), 32'h00);

        // fill, overflow, drain
        step(1, 0, 8'h11, "fill1");
        step(1, 0, 8'h22, "fill2");
        step(1, 0, 8'h33, "fill3");
        step(1, 0, 8'h44, "fill4");
        check("full_after4", 32'(full), 32'd1);
        step(1, 0, 8'h55, "overflow");
        for (int i = 0; i < 4; i++) step(0, 1, 8'h00, "drain");
        check("drained_empty", 32'(empty), 32'd1);

        // underflow reads are ignored
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00, "underflow");
        step(1, 0, 8'hA5, "after_underflow");
        check("a5_readback", 32'(r_data), 32'hA5);
        step(0, 1, 8'h00, "pop_a5");

        // simultaneous rd+wr while empty: only the write happens
        step(1, 1, 8'h5A, "rw_empty");
        check("rw_empty.data", 32'(r_data), 32'h5A);
        step(0, 1, 8'h00, "pop_5a");

        // simultaneous rd+wr while full
        for (int i = 1; i <= 4; i++) step(1, 0, 8'(i), "fill_num");
        step(1, 1, 8'h05, "rw_full");
        check("rw_full.data", 32'(r_data), 32'h02);
        check("rw_full.full", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 1, 8'h00, "drain_num");

        // wrap both pointers, then asynchronous reset between edges
        for (int i = 0; i < 10; i++) step(1, 1, 8'(8'hC0 + i), "wrap");
        step(1, 0, 8'h77, "pre_reset");
        wr = 1'b1;
        w_data = 8'h99;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_q.delete();
        check("async.empty",  32'(empty),  32'd1);
        check("async.full",   32'(full),   32'd0);
        check("async.r_data", 32'(r_data), 32'h00);
`ifdef UART_FIFO_COUNT_EN
        check("async.count",  32'(count),  32'd0);
`endif
        wr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_state("post_reset");

        // after reset writes land in entry 0, so a full drain leaves r_data on entry 0
        first = 8'($urandom_range(1, 255));
        step(1, 0, first, "restart_w0");
        for (int i = 1; i < 4; i++) step(1, 0, 8'($urandom), "restart_w");
        for (int i = 0; i < 4; i++) step(0, 1, 8'h00, "restart_r");
        check("restart.entry0", 32'(r_data), 32'(first));

        // randomized traffic with varying bias
        for (int phase = 0; phase < 4; phase++) begin
            int wp, rp;
            wp = 30 + phase * 15;
            rp = 75 - phase * 15;
            for (int i = 0; i < 100; i++) begin
                step(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp),
                     8'($urandom), "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_fifo.md
# uart_fifo

Synchronous FIFO that buffers bytes between the UART receiver and the loop-back consumer, and between that consumer and the UART transmitter. The receive-side instance supplies `empty`/`r_data` to the consumer and accepts its read strobe. The transmit-side instance accepts the consumer's write strobe and data and reports `full`. Reads are first-word-fall-through: the head entry is always visible on `r_data`.

## Interface
Parameters:
- `B`, 8: data width in bits.
- `W`, 2: address width; depth = 2^W entries (4 by default).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `rd`, input, 1: read strobe; pops the head entry when `empty`=0.
- `wr`, input, 1: write strobe; pushes `w_data` when accepted (see Operation).
- `w_data`, input, B: write data.
- `r_data`, output, B: head entry (combinational read of storage at read pointer).
- `empty`, output, 1: FIFO holds 0 entries.
- `full`, output, 1: FIFO holds 2^W entries.
- `count`, output, W+1: occupancy, 0..2^W. Present only with `UART_FIFO_COUNT_EN`.

## Operation
- **State**
  - Storage array of 2^W×B.
  - `w_ptr` and `r_ptr` are W bits each and wrap modulo 2^W.
  - `empty` and `full` are registered flags.
- **Reset** (`reset_n`=0, asynchronous): `w_ptr`=0, `r_ptr`=0, `empty`=1, `full`=0, all storage=0 (so `r_data`=0), `count`=0.
- **Per-cycle decode** on {wr, rd}:
  - 00: no change.
  - 10, write only:
    - If `full`=1, ignored; nothing changes.
    - Otherwise store `w_data` at `w_ptr` and increment `w_ptr`.
    - `empty`←0.
    - `full`←1 if the next `w_ptr` equals `r_ptr`.
  - 01, read only:
    - If `empty`=1, ignored; nothing changes.
    - Otherwise increment `r_ptr`.
    - `full`←0.
    - `empty`←1 if the next `r_ptr` equals `w_ptr`.
  - 11, both:
    - If `empty`=1, only the write is performed (same as 10); the read is dropped.
    - If `full`=1, both are performed; both pointers advance and the flags are unchanged.
    - Otherwise both are performed and the flags are unchanged.
- **Occupancy:** never exceeds 2^W and never goes below 0. Overflow writes and underflow reads are silently discarded and leave no side effects.
- **Data content:** `r_data` shows `storage[r_ptr]` at all times. Its value while `empty`=1 is stale and must not be consumed.

## Timing
- Write to read: data written at edge N appears on `r_data`, with `empty`=0, after edge N. It can be read (popped) at edge N+1.
- Read: after the popping edge, `r_data` shows the next entry combinationally in the same cycle.
- Flags are registered. They change only on a rising edge or on reset assertion, never combinationally from `rd`/`wr`.
- Throughput: one push and one pop per cycle in steady state.
- Reset mid-operation: all contents are discarded immediately and outputs take their reset values without waiting for a clock. Operation resumes on the first edge after `reset_n` rises.

## Configuration
- `UART_FIFO_COUNT_EN` defined:
  - Port `count` [W:0] exists and is registered.
  - It increments on an accepted write-only, decrements on an accepted read-only, and is unchanged otherwise.
  - Reset value 0.
  - `count`==0 exactly when `empty`=1; `count`==2^W exactly when `full`=1.
- `UART_FIFO_COUNT_EN` undefined: the `count` port and its register are absent. All other behaviour is identical.

## Test plan (B=8, W=2)
- Reset, then idle → `empty`=1, `full`=0, `r_data`=0x00, `count`=0.
- Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles → `full`=1 after the 4th edge. A 5th write of 0x55 is ignored. Reading 4 times yields 0x11, 0x22, 0x33, 0x44, then `empty`=1.
- With the FIFO empty, assert rd alone for 3 cycles → pointers unchanged and `empty` stays 1. A following write of 0xA5 is read back as 0xA5.
- With the FIFO empty, pulse rd=wr=1 with 0x5A → `empty`=0, 0x5A on `r_data`, `count`=1.
- With the FIFO full (0x01..0x04), assert rd=wr=1 with 0x05 → `r_data`=0x02, `full` stays 1. Draining yields 0x02, 0x03, 0x04, 0x05.
- Run 10 write+read pairs to wrap both pointers, then assert `reset_n`=0 mid-burst, asynchronously between edges → `empty`=1, `full`=0, `count`=0 immediately. Post-reset writes restart at entry 0.
